// File: rtl/my_stream_buffer_if.sv
// my_stream_buffer_if: valid/ready stream bundle with FIFO occupancy.
// master = producer/consumer side, slave = the buffer itself.
interface my_stream_buffer_if #(
   parameter int WIDTH = 1,
   parameter int LANES = 2,
   parameter int DEPTH = 4
);
   localparam int DW = LANES * WIDTH;
   localparam int CW = $clog2(DEPTH + 1);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/my_stream_buffer.sv
// my_stream_buffer: LANES x WIDTH valid/ready FIFO of DEPTH entries.
// Optional MY_STREAM_BUFFER_BYPASS_EN: zero-latency pass-through when empty.
module my_stream_buffer #(
   parameter int WIDTH = 1,
   parameter int LANES = 2,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   my_stream_buffer_if.slave  bus
);
   localparam int DW = LANES * WIDTH;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] L_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] L_LAST = PW'(DEPTH - 1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_empty;
   logic          w_in_ready;
   logic          w_out_valid;
   logic [DW-1:0] w_out_data;
   logic          w_thru;
   logic          w_push;
   logic          w_pop;
   logic          w_wr;
   logic          w_rd;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == L_LAST) ? '0 : p + 1'b1;
   endfunction

   assign w_empty    = (r_count == '0);
   assign w_in_ready = (r_count < L_FULL);

`ifdef MY_STREAM_BUFFER_BYPASS_EN
   logic w_byp;
   // reset masks the bypass so outputs stay idle while reset is held
   assign w_byp       = reset_n && w_empty;
   assign w_out_valid = w_byp ? bus.in_valid : !w_empty;
   assign w_out_data  = w_byp ? bus.in_data : r_mem[r_rd_ptr];
   assign w_thru      = w_byp && bus.in_valid && bus.out_ready;
`else
   assign w_out_valid = !w_empty;
   assign w_out_data  = r_mem[r_rd_ptr];
   assign w_thru      = 1'b0;
`endif

   assign w_push = bus.in_valid && w_in_ready;
   assign w_pop  = w_out_valid && bus.out_ready;
   assign w_wr   = w_push && !w_thru;
   assign w_rd   = w_pop && !w_thru;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_data;
   assign bus.count     = r_count;

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_rd) r_rd_ptr <= f_inc(r_rd_ptr);
         unique case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // storage; cleared on reset so out_data is never X when idle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr) begin
         r_mem[r_wr_ptr] <= bus.in_data;
      end
   end
endmodule
